// File: rtl/mb16_booth_prep.sv
// Operand preparation for the radix-8 Booth multiplier: weight digit encoding
// held until the next load, plus a 2-stage my / 3*my multiplicand pipeline.
module mb16_booth_prep #(
    parameter  int WIDTH     = 16,
    localparam int GROUP_CNT = (WIDTH >> 2) + 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 w_load,
    input  logic [WIDTH-1:0]     x_in,
    output logic                 w_ready,
    output logic                 w_valid,
    output logic [GROUP_CNT-1:0] s,
    output logic [GROUP_CNT-1:0] d,
    output logic [GROUP_CNT-1:0] t,
    output logic [GROUP_CNT-1:0] q,
    output logic [GROUP_CNT-1:0] n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     y_in,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     my,
    output logic [WIDTH+1:0]     tmy
);
    localparam int EXT_W = 3 * GROUP_CNT + 1;

    logic               pending;
    logic [WIDTH-1:0]   x_reg;
    logic               v1;
    logic               v2;
    logic [WIDTH-1:0]   y1;
    logic               adv1;
    logic               adv2;
    logic               accept;
    logic [EXT_W-1:0]   ext;
    logic [3:0]         grp;
    logic [GROUP_CNT-1:0] s_nxt, d_nxt, t_nxt, q_nxt, n_nxt;
    logic [WIDTH+1:0]   ys;
    logic [WIDTH+1:0]   tmy_nxt;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1 && !pending;
    assign accept    = in_valid && in_ready;
    assign w_ready   = !v1 && !v2 && !accept;
    assign out_valid = v2;

    // Bit 0 is the implicit x[-1]=0, so group i reads ext[3i+3:3i].
    assign ext = {{(EXT_W - WIDTH - 1){x_reg[WIDTH-1]}}, x_reg, 1'b0};

    always_comb begin
        grp   = '0;
        s_nxt = '0;
        d_nxt = '0;
        t_nxt = '0;
        q_nxt = '0;
        n_nxt = '0;
        for (int i = 0; i < GROUP_CNT; i++) begin
            grp = ext[3*i +: 4];
            case (grp)
                4'b0001, 4'b0010: s_nxt[i] = 1'b1;
                4'b0011, 4'b0100: d_nxt[i] = 1'b1;
                4'b0101, 4'b0110: t_nxt[i] = 1'b1;
                4'b0111:          q_nxt[i] = 1'b1;
                4'b1000: begin q_nxt[i] = 1'b1; n_nxt[i] = 1'b1; end
                4'b1001, 4'b1010: begin t_nxt[i] = 1'b1; n_nxt[i] = 1'b1; end
                4'b1011, 4'b1100: begin d_nxt[i] = 1'b1; n_nxt[i] = 1'b1; end
                4'b1101, 4'b1110: begin s_nxt[i] = 1'b1; n_nxt[i] = 1'b1; end
                default: ;
            endcase
        end
    end

    assign ys      = {{2{y1[WIDTH-1]}}, y1};
    assign tmy_nxt = ys + {ys[WIDTH:0], 1'b0};

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending <= 1'b0;
            x_reg   <= '0;
            w_valid <= 1'b0;
            s       <= '0;
            d       <= '0;
            t       <= '0;
            q       <= '0;
            n       <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            y1      <= '0;
            my      <= '0;
            tmy     <= '0;
        end else begin
            pending <= w_load && w_ready;
            if (w_load && w_ready)
                x_reg <= x_in;
            if (pending) begin
                s       <= s_nxt;
                d       <= d_nxt;
                t       <= t_nxt;
                q       <= q_nxt;
                n       <= n_nxt;
                w_valid <= 1'b1;
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    my  <= y1;
                    tmy <= tmy_nxt;
                end
            end
            if (adv1) begin
                v1 <= accept;
                if (accept)
                    y1 <= y_in;
            end
        end
    end
endmodule

// File: tb/tb_mb16_booth_prep.sv
// Bench for mb16_booth_prep: weight vector table, random weights vs digit model,
// scoreboarded Y stream with backpressure, and hand-written corner sequences.
module tb_mb16_booth_prep;
    localparam int W = 16;
    localparam int G = 6;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         w_load = 1'b0;
    logic [W-1:0] x_in = '0;
    logic         w_ready, w_valid;
    logic [G-1:0] s, d, t, q, n;
    logic         in_valid = 1'b0;
    logic [W-1:0] y_in = '0;
    logic         in_ready, out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] my;
    logic [W+1:0] tmy;

    mb16_booth_prep #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .w_load(w_load), .x_in(x_in), .w_ready(w_ready),
        .w_valid(w_valid), .s(s), .d(d), .t(t), .q(q), .n(n),
        .in_valid(in_valid), .y_in(y_in), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .my(my), .tmy(tmy)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [G-1:0] s, d, t, q, n;
    } wvec_t;

    wvec_t tbl[9];

    // Reference: digit_i = -4*x[3i+2] + 2*x[3i+1] + x[3i] + x[3i-1] on the signed value.
    task automatic model(input logic [W-1:0] x, output logic [G-1:0] es, ed, et, eq, en);
        int xv, b3, b2, b1, b0, dg, mag;
        xv = int'($signed(x));
        es = '0; ed = '0; et = '0; eq = '0; en = '0;
        for (int g = 0; g < G; g++) begin
            b3 = (xv >>> (3*g + 2)) & 1;
            b2 = (xv >>> (3*g + 1)) & 1;
            b1 = (xv >>> (3*g)) & 1;
            b0 = (g == 0) ? 0 : ((xv >>> (3*g - 1)) & 1);
            dg = -4*b3 + 2*b2 + b1 + b0;
            mag = (dg < 0) ? -dg : dg;
            if (mag == 1) es[g] = 1'b1;
            if (mag == 2) ed[g] = 1'b1;
            if (mag == 3) et[g] = 1'b1;
            if (mag == 4) eq[g] = 1'b1;
            if (dg < 0)   en[g] = 1'b1;
        end
    endtask

    function automatic int recon();
        int acc = 0, mag, wt = 1;
        for (int g = 0; g < G; g++) begin
            mag = s[g] ? 1 : d[g] ? 2 : t[g] ? 3 : q[g] ? 4 : 0;
            acc += (n[g] ? -mag : mag) * wt;
            wt *= 8;
        end
        return acc;
    endfunction

    function automatic logic [W+1:0] triple(input logic [W-1:0] y);
        int v;
        v = int'($signed(y)) * 3;
        return v[W+1:0];
    endfunction

    // Scoreboard: accepted Y values in order, plus stall-hold tracking.
    logic [W-1:0] sbq[$];
    logic         hold = 1'b0;
    logic [W-1:0] hmy;
    logic [W+1:0] htmy;
    logic [W-1:0] e;

    always @(negedge CLK) begin
        if (RST) begin
            sbq.delete();
            hold = 1'b0;
        end else begin
            if (hold) chk("stall_hold", {out_valid, my, tmy}, {1'b1, hmy, htmy});
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("y_out", {my, tmy}, {e, triple(e)});
                end
            end
            hold = out_valid && !out_ready;
            hmy  = my;
            htmy = tmy;
            if (in_valid && in_ready) sbq.push_back(y_in);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sbq.size() != 0 || out_valid) && k < 20) begin tick(); k++; end
        chk("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    task automatic load_w(input logic [W-1:0] x, input string nm);
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        while (!w_ready && k < 50) begin tick(); k++; end
        chk({nm, "_w_ready"}, 64'(w_ready), 64'd1);
        w_load = 1'b1;
        x_in   = x;
        tick();
        w_load = 1'b0;
        #1;
        chk({nm, "_pending_in_ready"}, 64'(in_ready), 64'd0);
        tick();
    endtask

    task automatic chk_fields(input string nm, input logic [G-1:0] es, ed, et, eq, en);
        chk(nm, {w_valid, s, d, t, q, n}, {1'b1, es, ed, et, eq, en});
    endtask

    logic [G-1:0] ms, md, mt, mq, mn;
    logic [W-1:0] rx;
    logic [W-1:0] ys[4];
    logic [W+1:0] tc[4];
    logic         acc;
    int           idx;

    initial begin
        tbl[0] = '{16'h0001, 6'b000001, 6'b0, 6'b0, 6'b0, 6'b0};
        tbl[1] = '{16'hFFFF, 6'b000001, 6'b0, 6'b0, 6'b0, 6'b000001};
        tbl[2] = '{16'h0007, 6'b000011, 6'b0, 6'b0, 6'b0, 6'b000001};
        tbl[3] = '{16'h0004, 6'b000010, 6'b0, 6'b0, 6'b000001, 6'b000001};
        tbl[4] = '{16'h8000, 6'b100000, 6'b0, 6'b0, 6'b0, 6'b100000};
        tbl[5] = '{16'h0000, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
        tbl[6] = '{16'h7FFF, 6'b100001, 6'b0, 6'b0, 6'b0, 6'b000001};
        tbl[7] = '{16'h0003, 6'b0, 6'b0, 6'b000001, 6'b0, 6'b0};
        tbl[8] = '{16'h0002, 6'b0, 6'b000001, 6'b0, 6'b0, 6'b0};
        ys = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
        tc = '{18'h17FFD, 18'h28000, 18'h00000, 18'h3FFFD};

        tick(); tick();
        RST = 1'b0;
        #1;
        chk("reset_state", {out_valid, w_valid, s, d, t, q, n, my, tmy}, '0);

        foreach (tbl[i]) begin
            load_w(tbl[i].x, $sformatf("tbl%0d", i));
            chk_fields($sformatf("tbl%0d_fields", i), tbl[i].s, tbl[i].d, tbl[i].t, tbl[i].q, tbl[i].n);
        end

        for (int i = 0; i < 20; i++) begin
            rx = W'($urandom);
            load_w(rx, "rnd");
            model(rx, ms, md, mt, mq, mn);
            chk_fields($sformatf("rnd_fields_%h", rx), ms, md, mt, mq, mn);
            chk("rnd_recon", 64'(recon()), 64'(int'($signed(rx))));
        end

        // Back-to-back stream, no backpressure: output two cycles after presentation.
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 4);
            if (c < 4) y_in = ys[c];
            #1;
            if (c < 4) chk("stream_in_ready", 64'(in_ready), 64'd1);
            tick();
            if (c == 0) chk("stream_latency", 64'(out_valid), 64'd0);
            else chk($sformatf("stream_out%0d", c - 1), {out_valid, my, tmy}, {1'b1, ys[c-1], tc[c-1]});
        end
        drain();

        // Same stream with a 3-cycle stall; in_ready must drop once both stages fill.
        idx = 0;
        for (int c = 0; c < 30 && (idx < 4 || sbq.size() != 0 || out_valid); c++) begin
            in_valid  = (idx < 4);
            if (idx < 4) y_in = ys[idx];
            out_ready = !(c >= 2 && c <= 4);
            #1;
            if (c == 4) chk("stall_in_ready", 64'(in_ready), 64'd0);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        chk("stall_all_sent", 64'(idx), 64'd4);
        drain();

        // Weight load while a Y operand is in flight is ignored.
        load_w(16'h0007, "occ_pre");
        in_valid = 1'b1; y_in = 16'h1357;
        tick();
        in_valid = 1'b0;
        w_load = 1'b1; x_in = 16'h1234;
        #1;
        chk("occ_w_ready", 64'(w_ready), 64'd0);
        tick();
        w_load = 1'b0;
        tick(); tick();
        drain();
        chk_fields("occ_fields", 6'b000011, 6'b0, 6'b0, 6'b0, 6'b000001);

        // Simultaneous in_valid and w_load: Y wins.
        in_valid = 1'b1; y_in = 16'h2468; w_load = 1'b1; x_in = 16'h5555;
        #1;
        chk("simul_in_ready", 64'(in_ready), 64'd1);
        chk("simul_w_ready", 64'(w_ready), 64'd0);
        tick();
        in_valid = 1'b0; w_load = 1'b0;
        tick(); tick(); tick();
        chk_fields("simul_fields", 6'b000011, 6'b0, 6'b0, 6'b0, 6'b000001);
        drain();

        // Randomised stream with random backpressure.
        for (int c = 0; c < 300; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            y_in      = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset with two operands in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; y_in = 16'h1111;
        tick();
        y_in = 16'h2222;
        tick();
        in_valid = 1'b0;
        RST = 1'b1;
        tick();
        chk("mid_reset", {out_valid, w_valid, s, d, t, q, n, my, tmy}, '0);
        RST = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        chk("post_reset_idle", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mb16_booth_prep.md
Name: mb16_booth_prep

Overview:
- Operand-preparation front end for the radix-8 Booth multiplier core. It produces the pre-encoded digit fields and the multiplicand terms that the core consumes.
- Multiplier (weight) path: a signed weight X is encoded once into one-hot digit fields s/d/t/q/n. The fields are held frozen until the next weight load.
- Multiplicand path: a stream of signed Y operands passes through a 2-stage valid/ready pipeline that emits my = Y and tmy = 3·Y.

Parameters:
- WIDTH, 16, operand width. Legal values are 8, 12, 16, 20.
- GROUP_CNT, (WIDTH>>2)+2, number of Booth groups. Derived localparam, not overridable.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- w_load  in  1  weight load request
- x_in  in  WIDTH  signed weight
- w_ready  out  1  weight load accepted this cycle (pipeline empty)
- w_valid  out  1  digit fields hold a loaded weight
- s,d,t,q,n  out  GROUP_CNT each  one-hot magnitude ×1/×2/×3/×4, and negative flag, per group
- in_valid  in  1  Y operand valid
- y_in  in  WIDTH  signed multiplicand
- in_ready  out  1  Y accepted when in_valid && in_ready
- out_valid  out  1  my/tmy valid
- out_ready  in  1  downstream accepts
- my  out  WIDTH  registered Y
- tmy  out  WIDTH+2  registered 3·Y, two's complement

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge) clears the following to 0:
  - all stage valids, out_valid, w_valid;
  - s, d, t, q, n, my, tmy.
  - Reset mid-stream drops in-flight operands; no partial output is emitted.
- Weight encoding: sign-extend X to 3·GROUP_CNT+1 bits, with x[-1]=0. Group i uses b3=x[3i+2], b2=x[3i+1], b1=x[3i], b0=x[3i-1].
  - Digit = −4·b3 + 2·b2 + b1 + b0, range −4..+4.
  - |digit| 1/2/3/4 sets s/d/t/q[i] respectively; at most one of them is high.
  - n[i]=1 iff digit < 0. Digit 0 gives all five bits 0, including n.
  - Groups above the sign bit encode 0.
- Weight load timing:
  - w_ready = 1 iff both pipeline stages are empty and in_valid is not being accepted this cycle.
  - w_load && w_ready at edge k: s..n and w_valid=1 are visible after edge k+1. This is 1-cycle latency: x_in is registered, then encoded into the output register.
  - While a load is pending (cycle between k and k+1), in_ready=0.
  - w_load while w_ready=0 is ignored; no state change.
  - The digit fields never change except on an accepted load or reset.
- Y pipeline, stage 1: registers Y and v1.
- Y pipeline, stage 2: registers my=Y and tmy = sext(Y)+(sext(Y)<<1) at WIDTH+2 bits, with out_valid=v2. No overflow is possible.
- Latency: 2 cycles from acceptance to out_valid under no backpressure. Throughput: 1 operand per cycle.
- Backpressure:
  - stage2 advances iff !v2 || out_ready;
  - stage1 advances iff !v1 || stage2 advances;
  - in_ready = stage1 can advance && no pending weight load.
  - The design has no combinational path from out_ready to the data outputs.
- Outputs are held stable while out_valid && !out_ready.
- Simultaneous in_valid and w_load: the Y operand wins. in_ready=1, w_ready=0, and the load is ignored.

Test Plan:
- Reset, then load X=0x0001 → after 2 edges: w_valid=1, s=6'b000001, d=t=q=n=0.
- Load X=0xFFFF (−1) → s[0]=1, n[0]=1, all other group fields 0.
- Load X=0x0007 → s[0]=1, n[0]=1, s[1]=1. Load X=0x0004 → q[0]=1, n[0]=1, s[1]=1. Load X=0x8000 → s[5]=1, n[5]=1, groups 0–4 zero.
- Stream Y = 0x7FFF, 0x8000, 0x0000, 0xFFFF with out_ready=1:
  - outputs appear 2 cycles later, back-to-back;
  - tmy = 0x17FFD, 0x28000, 0x00000, 0x3FFFD.
- Same stream with out_ready low for 3 cycles mid-stream → in_ready drops when both stages are full; no loss, duplication or reordering; my/tmy held stable while stalled.
- w_load while the pipeline is occupied → ignored, fields unchanged.
- w_load together with in_valid → Y accepted, load ignored.
- RST asserted with 2 operands in flight → next cycle out_valid=0, w_valid=0, and all fields 0.
